// File: rtl/mux_arbiter4_if.sv
// mux_arbiter4_if
//   Bundles the request/select/capture signals between the round-robin
//   arbiter and the logic around the shared mux4_1.
//   Signals:
//     req        [3:0] request lines, one per requester
//     mux_out          result of the shared mux4_1
//     sel        [1:0] select driven to the mux4_1
//     grant      [3:0] one-hot (or zero) owner indication
//     busy             arbiter is not idle
//     dout             registered sample of mux_out taken during grant cycles
//     dout_valid       one-cycle strobe following each grant-cycle sample
//   Modports:
//     master : the arbiter side (drives sel/grant/busy/dout/dout_valid)
//     slave  : the requesters and mux side (drives req and mux_out)
interface mux_arbiter4_if;
  logic [3:0] req;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       dout;
  logic       dout_valid;

  modport master (
    input  req, mux_out,
    output sel, grant, busy, dout, dout_valid
  );

  modport slave (
    output req, mux_out,
    input  sel, grant, busy, dout, dout_valid
  );
endinterface

// File: rtl/mux_arbiter4.sv
// mux_arbiter4
//   Round-robin arbiter that shares one mux4_1 between four requesters.
//   It grants one owner at a time for at most HOLD_MAX cycles, then inserts
//   a one-cycle GAP before arbitrating again. While a grant is active the
//   mux result is registered onto dout, with dout_valid as a one-cycle strobe.
//   Parameters:
//     HOLD_MAX  maximum consecutive grant cycles per owner (1..15)
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  mux_arbiter4_if.master (req, mux_out in; sel, grant, busy,
//          dout, dout_valid out)
module mux_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  mux_arbiter4_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] sel_reg, sel_next;
  logic [3:0] grant_reg, grant_next;
  logic [3:0] hold_reg, hold_next;
  logic       dout_reg, dout_next;
  logic       dout_valid_reg, dout_valid_next;

  // Round-robin search: walk ptr+3 down to ptr+0 so that the candidate
  // closest to ptr is the last one written and therefore wins.
  logic       win_any;
  logic [1:0] win_idx;
  logic [1:0] cand;

  always_comb begin
    win_any = 1'b0;
    win_idx = ptr_reg;
    cand    = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_reg + 2'(k);
      if (bus.req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      ptr_reg        <= 2'd0;
      sel_reg        <= 2'd0;
      grant_reg      <= 4'b0000;
      hold_reg       <= 4'd0;
      dout_reg       <= 1'b0;
      dout_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      sel_reg        <= sel_next;
      grant_reg      <= grant_next;
      hold_reg       <= hold_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    sel_next        = sel_reg;
    grant_next      = grant_reg;
    hold_next       = hold_reg;
    dout_next       = dout_reg;
    dout_valid_next = 1'b0;

    case (state_reg)
      IDLE, GAP: begin
        if (win_any) begin
          state_next = GRANT;
          grant_next = 4'b0001 << win_idx;
          sel_next   = win_idx;
          hold_next  = 4'd0;
        end else begin
          state_next = IDLE;
          grant_next = 4'b0000;
        end
      end
      GRANT: begin
        // sel_reg doubles as the owner index for the whole grant.
        dout_next       = bus.mux_out;
        dout_valid_next = 1'b1;
        hold_next       = hold_reg + 4'd1;
        if (!bus.req[sel_reg] || hold_reg == HOLD_LAST) begin
          state_next = GAP;
          grant_next = 4'b0000;
          ptr_next   = sel_reg + 2'd1;
        end
      end
      default: begin
        // Unused encoding recovers to IDLE.
        state_next = IDLE;
        grant_next = 4'b0000;
      end
    endcase
  end

  assign bus.sel        = sel_reg;
  assign bus.grant      = grant_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;

endmodule

// File: tb/tb_mux_arbiter4.sv
// tb_mux_arbiter4
//   Drives two arbiters (HOLD_MAX=4 and HOLD_MAX=1) with the same request and
//   reset stimulus and compares every output each cycle against a
//   behavioural model. A mux4_1 is emulated with a random data nibble
//   indexed by each arbiter's sel.
module tb_mux_arbiter4;

  localparam int N_INST = 2;
  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_GAP   = 2;

  logic       clk;
  logic       rst;
  logic [3:0] req_v;
  logic [3:0] data_v;

  int checks;
  int errors;
  int cyc;

  mux_arbiter4_if ifc0 ();
  mux_arbiter4_if ifc1 ();

  assign ifc0.req     = req_v;
  assign ifc1.req     = req_v;
  assign ifc0.mux_out = data_v[ifc0.sel];
  assign ifc1.mux_out = data_v[ifc1.sel];

  mux_arbiter4 #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc0.master));
  mux_arbiter4 #(.HOLD_MAX(1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, one entry per instance.
  int         m_mode  [N_INST];
  int         m_held  [N_INST];   // grant cycles already delivered to owner
  int         m_hmax  [N_INST];
  int         m_ptr   [N_INST];
  int         m_owner [N_INST];
  logic [3:0] m_grant [N_INST];
  logic [1:0] m_sel   [N_INST];
  logic       m_dout  [N_INST];
  logic       m_dv    [N_INST];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Advance model i across the coming edge, given the inputs applied now.
  task automatic model_step(input int i);
    int w;
    if (rst) begin
      m_mode[i] = M_IDLE; m_ptr[i] = 0; m_sel[i] = 2'd0; m_grant[i] = 4'b0;
      m_dout[i] = 1'b0; m_dv[i] = 1'b0; m_held[i] = 0;
      return;
    end
    if (m_mode[i] == M_GRANT) begin
      m_dout[i] = data_v[m_owner[i]];
      m_dv[i]   = 1'b1;
      if (!req_v[m_owner[i]] || m_held[i] >= m_hmax[i]) begin
        m_mode[i]  = M_GAP;
        m_grant[i] = 4'b0;
        m_ptr[i]   = (m_owner[i] + 1) % 4;
      end else begin
        m_held[i]++;
      end
    end else begin
      m_dv[i] = 1'b0;
      w = pick(req_v, m_ptr[i]);
      if (w >= 0) begin
        m_mode[i]  = M_GRANT;
        m_owner[i] = w;
        m_sel[i]   = 2'(w);
        m_grant[i] = 4'(1 << w);
        m_held[i]  = 1;
        if (i == 0) $display("cycle %0d: HOLD_MAX=4 instance grants requester %0d (req=%b)", cyc + 1, w, req_v);
      end else begin
        m_mode[i] = M_IDLE;
      end
    end
  endtask

  task automatic compare_inst(input int i, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic d, input logic dv);
    string p;
    p = (i == 0) ? "h4" : "h1";
    check({p, "_grant"},  32'(g),  32'(m_grant[i]));
    check({p, "_sel"},    32'(s),  32'(m_sel[i]));
    check({p, "_busy"},   32'(b),  32'(m_mode[i] != M_IDLE));
    check({p, "_dvalid"}, 32'(dv), 32'(m_dv[i]));
    check({p, "_dout"},   32'(d),  32'(m_dout[i]));
    check({p, "_onehot"}, 32'($countones(g) > 1), 32'(0));
  endtask

  // Apply inputs for the next edge, update models, then check after the edge.
  task automatic cycle(input logic r, input logic [3:0] rq);
    rst    = r;
    req_v  = rq;
    data_v = 4'($urandom_range(0, 15));
    for (int i = 0; i < N_INST; i++) model_step(i);
    @(negedge clk);
    cyc++;
    compare_inst(0, ifc0.grant, ifc0.sel, ifc0.busy, ifc0.dout, ifc0.dout_valid);
    compare_inst(1, ifc1.grant, ifc1.sel, ifc1.busy, ifc1.dout, ifc1.dout_valid);
  endtask

  initial begin
    logic [3:0] rq;
    checks = 0;
    errors = 0;
    cyc    = 0;
    m_hmax[0] = 4;
    m_hmax[1] = 1;
    for (int i = 0; i < N_INST; i++) begin
      m_mode[i] = M_IDLE; m_held[i] = 0; m_ptr[i] = 0; m_owner[i] = 0;
      m_grant[i] = 4'b0; m_sel[i] = 2'd0; m_dout[i] = 1'b0; m_dv[i] = 1'b0;
    end

    $display("reset held with all requests high");
    cycle(1'b1, 4'b1111);
    cycle(1'b1, 4'b1111);

    $display("fairness / round robin with all four requesting");
    for (int n = 0; n < 24; n++) cycle(1'b0, 4'b1111);

    $display("timeout and round robin with req=0101");
    cycle(1'b1, 4'b0101);
    for (int n = 0; n < 14; n++) cycle(1'b0, 4'b0101);

    $display("single requester early release");
    cycle(1'b1, 4'b0000);
    for (int n = 0; n < 3; n++) cycle(1'b0, 4'b0100);
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'b0000);

    $display("reset in the middle of a grant to requester 3");
    cycle(1'b0, 4'b1000);
    cycle(1'b0, 4'b1000);
    cycle(1'b1, 4'b1001);
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b1001);

    $display("late requester arrives during a grant");
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    cycle(1'b0, 4'b1010);
    for (int n = 0; n < 6; n++) cycle(1'b0, 4'b1110);
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'b1010);

    $display("randomized traffic");
    rq = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 127) == 0), rq);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter4.md
# mux_arbiter4

Round-robin arbiter that shares one `mux4_1` between four single-bit requesters. It picks an owner and drives the mux select lines, holds the grant for a bounded time, then inserts a one-cycle turnaround gap. While a grant is active, it also registers the mux output for downstream logic. It sits directly upstream of `mux4_1`: `sel` goes to the mux, and the mux `result` returns on `mux_out`.

## Interface

- `HOLD_MAX`, default 8: maximum consecutive grant cycles per owner; legal range 1..15; the hold counter is 4 bits.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 4: request lines; `req[i]` high means requester i wants the mux.
- `mux_out` input 1: the `result` output of the shared `mux4_1`.
- `sel` output 2: registered select to the `mux4_1` `sel` input.
- `grant` output 4: registered, one-hot or zero; `grant[i]` marks requester i as owner.
- `busy` output 1: high whenever the state is not IDLE; decoded from the state register.
- `dout` output 1: registered sample of `mux_out`, taken during grant cycles.
- `dout_valid` output 1: high for one cycle after each grant-cycle sample.

## Operation

- **States:** IDLE (00), GRANT (01), GAP (10). Encoding 11 is unused and must go to IDLE on the next edge.
- **Round-robin pointer:**
  - `ptr[1:0]` names the highest-priority requester.
  - The search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4), and the first requester with `req` high wins.
- **IDLE:**
  - If `req` is 0000, remain in IDLE.
  - Otherwise:
    - arbitrate;
    - on the edge, load `grant` with the one-hot winner and `sel` with the winner index;
    - clear `hold_cnt` to 0;
    - go to GRANT.
- **GRANT:**
  - Each edge, `hold_cnt` increments.
  - Exit to GAP on the first edge where either condition holds:
    - `req[owner]` is sampled low;
    - `hold_cnt == HOLD_MAX-1` is sampled.
  - On exit:
    - `grant` goes to 0000;
    - `ptr` becomes owner+1 (mod 4);
    - `sel` holds its value.
- **GAP:** exactly one cycle with `grant` at 0000.
  - Arbitrate exactly as in IDLE, using the updated `ptr`.
  - If there is a winner, go to GRANT.
  - If there is none, go to IDLE.
- **Data capture:**
  - On every edge taken in GRANT, load `dout` with `mux_out` and set `dout_valid` to 1.
  - In every other state, clear `dout_valid` to 0 and let `dout` hold.
- **Hold timing:**
  - A held request receives exactly HOLD_MAX grant cycles.
  - With `HOLD_MAX=1`, every grant lasts one cycle.
- **Request changes mid-grant:** other requesters' `req` changes during GRANT have no effect until the next arbitration.

## Timing

- **Reset:** when `rst` is high at an edge, the following load on that edge:
  - state IDLE;
  - `ptr`, `sel` and `hold_cnt` to 0;
  - `grant` to 0000;
  - `dout` and `dout_valid` to 0.
- **Reset priority:** reset overrides all other behaviour, including reset arriving in the middle of a GRANT; no GAP cycle is inserted.
- **Request latency:** a `req` sampled at edge N in IDLE produces `grant` and `sel` valid after edge N, i.e. in cycle N+1.
- **Gap between grants:** back-to-back grants to different owners are separated by exactly one cycle with `grant` at 0000.
- **Capture latency:**
  - `dout` and `dout_valid` lag the corresponding grant cycle by one cycle.
  - The last `dout_valid` pulse of a grant falls in the GAP cycle.
- **Output invariants:**
  - `grant` is never multi-hot.
  - `sel` always equals the index of the set `grant` bit while `grant` is non-zero.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `req=1111` -> `grant`=0000, `sel`=0, `busy`=0, `dout_valid`=0 throughout; first grant appears 1 cycle after `rst` falls, `grant`=0001.
- **Single requester, early release:**
  - Stimulus: `req=0100` for 3 cycles, then 0000.
  - Required:
    - `grant`=0100 and `sel`=2 for 3 cycles;
    - one GAP cycle, then IDLE;
    - `dout_valid` high for 3 cycles, each `dout` equal to the `mux_out` of the previous cycle.
- **Timeout and round robin:**
  - Stimulus: `HOLD_MAX=4`, `req=0101` held continuously from reset release.
  - Required:
    - `grant`=0001 for cycles 1-4;
    - GAP at cycle 5;
    - `grant`=0100 for cycles 6-9;
    - GAP at cycle 10;
    - `grant`=0001 from cycle 11.
- **Fairness across all four:** `req=1111` continuously with `HOLD_MAX=1` -> the grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001 repeats.
- **Reset mid-grant:**
  - Stimulus: `rst` pulses on the 2nd cycle of a `grant`=1000 period.
  - Required:
    - the next cycle shows `grant`=0000, `sel`=0, `dout_valid`=0;
    - `ptr` is back at 0, so with `req=1001` the next grant is 0001.
- **Late requester during grant:**
  - Stimulus: `req[3]` rises while requester 1 holds the grant.
  - Required:
    - owner 1 keeps the grant until release or timeout;
    - then GAP;
    - then `grant`=1000, or `grant`=0100 if `req[2]` is also high, because `ptr`=2.
